// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, 8N1 frame recovery, byte output on a valid/ready handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  localparam int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t        state;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_done;
  logic          clk_last;
  logic          byte_ok;

  assign rxs      = sync_q[1];
  assign clk_last = (clk_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = (^shift) ^ par_bit;
  assign byte_ok = rxs & ~par_bad;
`else
  assign byte_ok = rxs;
`endif

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  // byte_done is a one-cycle strobe so delivery lands one edge after the stop-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_last) begin
            clk_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_last) begin
            clk_cnt <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (clk_last) begin
            clk_cnt   <= '0;
            byte_done <= byte_ok;
            frame_err <= ~rxs;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            state     <= rxs ? IDLE : BREAK;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An acceptance in the same cycle as a new byte frees the slot, so the new byte wins
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (byte_done) begin
      if (!rx_valid || rx_ready) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // edge (after the start-bit fall) at which the stop bit is judged
  localparam int DECIDE = HALF + (NBITS - 1) * CPB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
  } ev_t;

  ev_t evq[$];

  int checks = 0;
  int errors = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovr = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;
  logic       ready_q = 1'b0;
  logic       rst_q = 1'b1;

  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic       prev_valid = 1'b0;
  bit         rand_ready_en = 1'b0;

  // Frame-level model: each queued frame resolves at its decision edge, bytes land one edge later
  task automatic modelStep();
    ev_t e;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    if (rst_q) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovr   = 1'b0;
      pend    = 1'b0;
      evq.delete();
    end else begin
      if (pend) begin
        if (!m_valid || ready_q) begin
          m_data  = pend_data;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready_q) begin
        m_valid = 1'b0;
      end
      pend = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        exp_ferr = !e.stop_ok;
        exp_perr = !e.par_ok;
        if (e.stop_ok && e.par_ok) begin
          pend      = 1'b1;
          pend_data = e.data;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checks++;
    if (rx_valid !== m_valid) begin
      errors++;
      $display("[TB] FAIL rx_valid cyc=%0d got=%b exp=%b", cyc, rx_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (rx_data !== m_data) begin
        errors++;
        $display("[TB] FAIL rx_data cyc=%0d got=%h exp=%h", cyc, rx_data, m_data);
      end
    end
    checks++;
    if (frame_err !== exp_ferr) begin
      errors++;
      $display("[TB] FAIL frame_err cyc=%0d got=%b exp=%b", cyc, frame_err, exp_ferr);
    end
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("[TB] FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, m_ovr);
    end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (parity_err !== exp_perr) begin
      errors++;
      $display("[TB] FAIL parity_err cyc=%0d got=%b exp=%b", cyc, parity_err, exp_perr);
    end
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      modelStep();
      checkOutput();
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
        rise_cnt++;
        rise_cyc  = cyc;
        rise_data = rx_data;
      end
      prev_valid = rx_valid;
      if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) perr_cnt++;
`endif
      ready_q = rx_ready;
      rst_q   = rst;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkLit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Drives one frame starting now (caller sits just after a clock edge); abort_bit>=0 stops mid-frame
  task automatic applyStimulus(input logic [7:0] d, input bit stop_bit, input bit par_bad,
                               input int abort_bit, output int start_cyc);
    logic [NBITS-1:0] fr;
    ev_t e;
    fr = '0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9] = (^d) ^ par_bad;
`endif
    fr[NBITS-1] = stop_bit;
    start_cyc = cyc;
    if (abort_bit < 0) begin
      e.cyc     = cyc + DECIDE;
      e.data    = d;
      e.stop_ok = stop_bit;
      e.par_ok  = !par_bad;
      evq.push_back(e);
    end
    for (int i = 0; i < NBITS; i++) begin
      rx = fr[i];
      if (i == abort_bit) begin
        idle(2);
        return;
      end
      idle(CPB);
    end
  endtask

  int         sc;
  int         r0;
  int         f0;
  int         p0;
  int         lat;
  logic [7:0] rd;
  bit         bad_stop;
  bit         bad_par;

  initial begin
    idle(3);
    checkLit("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkLit("reset_rx_data", 32'(rx_data), 32'd0);
    checkLit("reset_frame_err", 32'(frame_err), 32'd0);
    checkLit("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(4);

    rx_ready = 1'b1;
    r0 = rise_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, sc);
    idle(8);
    lat = rise_cyc - sc;
    checkLit("nominal_one_byte", 32'(rise_cnt - r0), 32'd1);
    checkLit("nominal_data", 32'(rise_data), 32'hA5);
    checkLit("nominal_latency", 32'(lat >= HALF + (NBITS - 1) * CPB + 2 &&
                                    lat <= HALF + (NBITS - 1) * CPB + 4), 32'd1);
    checkLit("nominal_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    checkLit("nominal_no_overrun", 32'(overrun), 32'd0);

    rx_ready = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b0, -1, sc);
    applyStimulus(8'hFF, 1'b1, 1'b0, -1, sc);
    idle(3);
    checkLit("stall_valid_held", 32'(rx_valid), 32'd1);
    checkLit("stall_data_kept", 32'(rx_data), 32'h00);
    checkLit("stall_overrun", 32'(overrun), 32'd1);
    rx_ready = 1'b1;
    idle(1);
    checkLit("stall_valid_drop", 32'(rx_valid), 32'd0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    checkLit("overrun_cleared_by_rst", 32'(overrun), 32'd0);

    r0 = rise_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(10);
    checkLit("false_start_no_valid", 32'(rise_cnt - r0), 32'd0);
    checkLit("false_start_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0, -1, sc);
    idle(6);
    checkLit("after_false_start_byte", 32'(rise_cnt - r0), 32'd1);
    checkLit("after_false_start_data", 32'(rise_data), 32'h3C);

    r0 = rise_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'h55, 1'b0, 1'b0, -1, sc);
    idle(20);
    rx = 1'b1;
    idle(6);
    checkLit("ferr_one_cycle", 32'(ferr_cnt - f0), 32'd1);
    checkLit("ferr_no_valid", 32'(rise_cnt - r0), 32'd0);
    applyStimulus(8'h81, 1'b1, 1'b0, -1, sc);
    idle(6);
    checkLit("after_ferr_data", 32'(rise_data), 32'h81);

    r0 = rise_cnt;
    applyStimulus(8'hC3, 1'b1, 1'b0, 5, sc);
    rst = 1'b1;
    rx  = 1'b1;
    idle(1);
    checkLit("midreset_rx_valid", 32'(rx_valid), 32'd0);
    checkLit("midreset_rx_data", 32'(rx_data), 32'd0);
    checkLit("midreset_frame_err", 32'(frame_err), 32'd0);
    checkLit("midreset_overrun", 32'(overrun), 32'd0);
    idle(1);
    rst = 1'b0;
    idle(4);
    applyStimulus(8'h7E, 1'b1, 1'b0, -1, sc);
    idle(6);
    checkLit("midreset_one_byte", 32'(rise_cnt - r0), 32'd1);
    checkLit("midreset_next_data", 32'(rise_data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    r0 = rise_cnt;
    p0 = perr_cnt;
    applyStimulus(8'h03, 1'b1, 1'b0, -1, sc);
    idle(6);
    checkLit("parity_good_byte", 32'(rise_cnt - r0), 32'd1);
    checkLit("parity_good_data", 32'(rise_data), 32'h03);
    applyStimulus(8'h03, 1'b1, 1'b1, -1, sc);
    idle(6);
    checkLit("parity_bad_pulse", 32'(perr_cnt - p0), 32'd1);
    checkLit("parity_bad_no_valid", 32'(rise_cnt - r0), 32'd1);
`else
    p0 = perr_cnt;
`endif

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    rand_ready_en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rd       = 8'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
      bad_par  = ($urandom_range(0, 7) == 0);
`else
      bad_par  = 1'b0;
`endif
      applyStimulus(rd, !bad_stop, bad_par, -1, sc);
      if (bad_stop) begin
        idle($urandom_range(1, 15));
        rx = 1'b1;
        idle(3);
      end else begin
        idle($urandom_range(0, 3));
      end
    end
    rand_ready_en = 1'b0;
    rx_ready = 1'b1;
    idle(DECIDE + 10);
    checkLit("random_drained", 32'(evq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
